// File: rtl/quadra_coef_loader_pkg.sv
// Shared types for the coefficient loader and the table it writes.
package quadra_coef_loader_pkg;
  localparam int A_W  = 24;
  localparam int B_W  = 20;
  localparam int C_W  = 16;
  localparam int X1_W = 7;

  typedef logic [A_W-1:0]  a_t;
  typedef logic [B_W-1:0]  b_t;
  typedef logic [C_W-1:0]  c_t;
  typedef logic [X1_W-1:0] x1_t;

  localparam logic [7:0] QCL_HDR       = 8'hA5;
  localparam int         QCL_FRAME_LEN = 11;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_INDEX,
    ST_COEF,
    ST_CHECK,
    ST_WRITE
  } qcl_state_t;
endpackage

// File: rtl/quadra_coef_loader_if.sv
// Byte stream in, table write bus and status out.
interface quadra_coef_loader_if;
  import quadra_coef_loader_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  x1_t        wr_addr;
  a_t         wr_a;
  b_t         wr_b;
  c_t         wr_c;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_a, wr_b, wr_c, frame_ok, frame_err, err_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_a, wr_b, wr_c, frame_ok, frame_err, err_cnt
  );
endinterface

// File: rtl/quadra_coef_loader.sv
// Byte-serial loader: parses 11-byte coefficient frames, validates index,
// XOR checksum and inter-byte timeout, and writes (a, b, c) to entry x1.
// Note: rst_b is active-high despite its name.
module quadra_coef_loader
  import quadra_coef_loader_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_b,
  quadra_coef_loader_if.slave bus
);
  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [2:0] COEF_LAST = 3'(QCL_FRAME_LEN - 4);

  qcl_state_t    state, state_nxt;
  logic [2:0]    byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    csum;
  logic [63:0]   asm_q;
  x1_t           idx_q;
  logic          acc, timed_state, timed_out, good, bad;
  logic          unused_nib;

  assign acc         = bus.in_valid && bus.in_ready;
  assign timed_state = (state == ST_INDEX) || (state == ST_COEF) || (state == ST_CHECK);
  assign timed_out   = timed_state && (idle_cnt == TW'(TIMEOUT));
  assign bus.in_ready = (state != ST_WRITE);
  // upper nibble of byte 5 is carried in the shift register but never used
  assign unused_nib  = ^asm_q[39:36];

  // state register
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  // next state plus accept/reject decisions; timeout overrides any byte
  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    if (timed_out) begin
      state_nxt = ST_HUNT;
      bad       = 1'b1;
    end else begin
      case (state)
        ST_HUNT:  if (acc && bus.in_data == QCL_HDR) state_nxt = ST_INDEX;
        ST_INDEX: if (acc) begin
          if (bus.in_data[7]) begin
            bad       = 1'b1;
            state_nxt = ST_HUNT;
          end else begin
            state_nxt = ST_COEF;
          end
        end
        ST_COEF:  if (acc && byte_cnt == COEF_LAST) state_nxt = ST_CHECK;
        ST_CHECK: if (acc) begin
          if (bus.in_data == csum) begin
            good      = 1'b1;
            state_nxt = ST_WRITE;
          end else begin
            bad       = 1'b1;
            state_nxt = ST_HUNT;
          end
        end
        ST_WRITE: state_nxt = ST_HUNT;
        default:  state_nxt = ST_HUNT;
      endcase
    end
  end

  // idle counter: cleared by any accepted byte, any state change, and outside timed states
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)                                     idle_cnt <= '0;
    else if (acc || state_nxt != state || !timed_state) idle_cnt <= '0;
    else                                           idle_cnt <= idle_cnt + TW'(1);
  end

  // frame assembly: running checksum, index latch, coefficient shift register
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      csum     <= '0;
      idx_q    <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
    end else if (acc && !timed_out) begin
      case (state)
        ST_HUNT:  if (bus.in_data == QCL_HDR) csum <= '0;
        ST_INDEX: begin
          csum     <= csum ^ bus.in_data;
          idx_q    <= bus.in_data[6:0];
          byte_cnt <= '0;
        end
        ST_COEF: begin
          csum     <= csum ^ bus.in_data;
          asm_q    <= {asm_q[55:0], bus.in_data};
          byte_cnt <= byte_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // registered outputs: write strobe/data, status pulses, saturating error count
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      bus.wr_en     <= 1'b0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_a      <= '0;
      bus.wr_b      <= '0;
      bus.wr_c      <= '0;
      bus.err_cnt   <= '0;
    end else begin
      bus.wr_en     <= good;
      bus.frame_ok  <= good;
      bus.frame_err <= bad;
      if (good) begin
        bus.wr_addr <= idx_q;
        bus.wr_a    <= asm_q[63:40];
        bus.wr_b    <= asm_q[35:16];
        bus.wr_c    <= asm_q[15:0];
      end
      if (bad && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end
endmodule

// File: doc/quadra_coef_loader.md
# quadra_coef_loader

Byte-serial coefficient loader for the quadratic evaluator's piecewise table. It receives framed coefficient records over a valid/ready byte stream and validates each frame's index, checksum and inter-byte timeout. For every good frame it issues one write of (a, b, c) to the coefficient table entry addressed by x1, the 7-bit segment index the evaluator reads from. It is the writer side of the table the evaluator reads.

## Interface
- TIMEOUT, 1023: maximum idle cycles between accepted bytes inside a frame before abort.
- clk  in  1  clock (ck_t); all state updates on the rising edge.
- rst_b  in  1  reset (rs_t); asynchronous, active-high.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle table write strobe.
- wr_addr  out  7  table index (x1_t).
- wr_a  out  24  coefficient a (a_t).
- wr_b  out  20  coefficient b (b_t).
- wr_c  out  16  coefficient c (c_t).
- frame_ok  out  1  one-cycle pulse coincident with wr_en.
- frame_err  out  1  one-cycle pulse on any frame rejection.
- err_cnt  out  8  count of rejected frames, saturates at 255.

## Operation
- A byte transfers on a rising edge where in_valid && in_ready.
- Frame is 11 bytes:
  - byte 0: header 0xA5
  - byte 1: index; bit 7 must be 0
  - bytes 2–4: a, MSB first
  - bytes 5–7: b, MSB first; the upper 4 bits of byte 5 are ignored
  - bytes 8–9: c, MSB first
  - byte 10: checksum
- Checksum is the XOR of bytes 1–9. A mismatch rejects the frame.
- FSM states:
  - HUNT: non-0xA5 bytes are consumed and dropped silently, with no error. 0xA5 moves to INDEX.
  - INDEX: bit 7 set → frame_err, return to HUNT. Otherwise latch the index and go to COEF.
  - COEF: a 3-bit byte counter runs 0..7 and shifts bytes into a 64-bit assembly register. After byte 7, go to CHECK.
  - CHECK: checksum match → WRITE. Mismatch → frame_err, return to HUNT.
  - WRITE: one cycle; return to HUNT.
- The running XOR clears on header acceptance and accumulates every later byte except the checksum byte.
- Timeout applies in INDEX, COEF and CHECK only:
  - An idle counter clears on each accepted byte and on entry to the state.
  - When it reaches TIMEOUT, assert frame_err and return to HUNT. The partial frame is discarded with no write.
- err_cnt increments on every frame_err and saturates at 255.
- A 0xA5 inside a frame is ordinary data. There is no resynchronisation on header inside a frame.

## Timing
- Reset values:
  - state HUNT
  - wr_en, frame_ok, frame_err = 0
  - wr_addr, wr_a, wr_b, wr_c = 0
  - err_cnt = 0
  - in_ready = 1 (decoded from state)
- in_ready = 0 only in WRITE; otherwise 1. There is no combinational path from in_valid to in_ready.
- All other outputs are registered.
- If the checksum byte is accepted at edge N:
  - wr_en, frame_ok and wr_addr/wr_a/wr_b/wr_c are valid in the cycle after edge N.
  - in_ready is low for that same cycle.
  - The next header can be accepted at edge N+2.
- wr_a/wr_b/wr_c/wr_addr hold their last written value between writes.
- A rejection detected on byte acceptance at edge N (bad index or bad checksum) gives frame_err high in the cycle after edge N.
- A timeout gives frame_err high in the cycle after the counter reaches TIMEOUT.
- Minimum frame-to-frame period is 12 cycles.
- Asserting rst_b mid-frame asynchronously discards the partial frame: no write, no frame_err, err_cnt cleared.

## Structure
- Shared header quadra.vh gains:
  - A_W=24, B_W=20, C_W=16
  - matching a_t, b_t, c_t (reused by the table)
  - QCL_HDR=8'hA5, QCL_FRAME_LEN=11
  - state enum qcl_state_t
- Single module; no sub-module is natural. The timeout counter is sized $clog2(TIMEOUT+1).

## Test plan
- Good frame: A5 05 01 23 45 0A BC DE 7F FF 8A → one wr_en with wr_addr=5, wr_a=0x012345, wr_b=0xABCDE, wr_c=0x7FFF, frame_ok=1; err_cnt=0.
- Bad checksum: same frame with last byte 8B → no wr_en, one frame_err, err_cnt=1. The following good frame writes normally.
- Bad index: A5 85 … → frame_err one cycle after the index byte. The remaining bytes are hunted (dropped), and the next A5 starts a new frame.
- Timeout with TIMEOUT=16: A5 05 01, then in_valid=0 for 16 cycles → frame_err, no write. A subsequent good frame is accepted.
- Back-to-back frames with in_valid held high:
  - in_ready drops exactly one cycle after each checksum byte.
  - Two writes occur 12 cycles apart.
  - err_cnt saturates at 255 after 300 bad frames.
- Reset mid-frame after byte 6 → all outputs return to reset values, no write. A fresh good frame then writes correctly.
